// File: rtl/mem_access_unit_pkg.sv
// Shared types, funct3 constants and store-lane helpers for mem_access_unit.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

  // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes never fault.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b01:   is_misaligned = off[0];
      2'b10:   is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   store_strb = 4'b0001 << off;
      2'b01:   store_strb = 4'b0011 << off;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-oriented memory bus between mem_access_unit (master) and the memory (slave).
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// load_align: moves the addressed byte/half of a read word to bit 0 and extends it.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_size,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_word >> {i_off, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_size)
      F3_LB:   o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_LW:   o_data = w_shifted;
      F3_LBU:  o_data = {24'd0, w_shifted[7:0]};
      F3_LHU:  o_data = {16'd0, w_shifted[15:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: IDLE -> BUSY (bus held) -> DONE (pipeline advances).
// Optional bus timeout with bus_err output when MEM_TIMEOUT_EN is defined.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [2:0]        mem_size,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_stall,
  output logic [31:0]       mem_rdata,
  output logic              rdata_valid,
  output logic              misalign,
  mem_access_unit_if.master bus
`ifdef MEM_TIMEOUT_EN
  ,
  output logic              bus_err
`endif
);

  state_t      r_state;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_wstrb;
  logic [2:0]  r_size;
  logic [1:0]  r_off;
  logic [31:0] r_mem_rdata;
  logic        r_rdata_valid;
  logic        r_misalign;
  logic        w_misaligned;
  logic [31:0] w_load_data;
`ifdef MEM_TIMEOUT_EN
  logic [7:0]  r_cnt;
  logic        r_bus_err;
`endif

  assign w_misaligned = mem_req && is_misaligned(mem_size[1:0], mem_addr[1:0]);
  assign mem_stall    = mem_req && (r_state != ST_DONE) && !w_misaligned;

  load_align u_load_align (
    .i_word (bus.bus_rdata),
    .i_off  (r_off),
    .i_size (r_size),
    .o_data (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_bus_req     <= 1'b0;
      r_bus_we      <= 1'b0;
      r_bus_addr    <= 32'd0;
      r_bus_wdata   <= 32'd0;
      r_bus_wstrb   <= 4'd0;
      r_size        <= 3'd0;
      r_off         <= 2'd0;
      r_mem_rdata   <= 32'd0;
      r_rdata_valid <= 1'b0;
      r_misalign    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_cnt         <= 8'd0;
      r_bus_err     <= 1'b0;
`endif
    end else begin
      r_rdata_valid <= 1'b0;
      r_misalign    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_bus_err     <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_misaligned) begin
            r_misalign <= 1'b1;
          end else if (mem_req) begin
            r_state     <= ST_BUSY;
            r_bus_req   <= 1'b1;
            r_bus_we    <= mem_we;
            r_bus_addr  <= {mem_addr[31:2], 2'b00};
            r_bus_wdata <= mem_we ? store_data(mem_size[1:0], mem_wdata) : 32'd0;
            r_bus_wstrb <= mem_we ? store_strb(mem_size[1:0], mem_addr[1:0]) : 4'd0;
            r_size      <= mem_size;
            r_off       <= mem_addr[1:0];
`ifdef MEM_TIMEOUT_EN
            r_cnt       <= 8'd0;
`endif
          end
        end
        ST_BUSY: begin
          if (bus.bus_ack) begin
            r_state   <= ST_DONE;
            r_bus_req <= 1'b0;
            if (!r_bus_we) begin
              r_mem_rdata   <= w_load_data;
              r_rdata_valid <= 1'b1;
            end
`ifdef MEM_TIMEOUT_EN
          end else if (r_cnt + 8'd1 == TIMEOUT_LIMIT) begin
            // Give up: release the pipeline with a zero result and flag the error.
            r_state   <= ST_DONE;
            r_bus_req <= 1'b0;
            r_bus_err <= 1'b1;
            r_cnt     <= TIMEOUT_LIMIT;
            if (!r_bus_we) begin
              r_mem_rdata   <= 32'd0;
              r_rdata_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
`endif
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_wdata = r_bus_wdata;
  assign bus.bus_wstrb = r_bus_wstrb;
  assign mem_rdata     = r_mem_rdata;
  assign rdata_valid   = r_rdata_valid;
  assign misalign      = r_misalign;
`ifdef MEM_TIMEOUT_EN
  assign bus_err       = r_bus_err;
`endif

endmodule
